// File: rtl/uart_report_scheduler_if.sv
// Handshake bundle between the counter bank, the report scheduler and the UART transmitter.
// The scheduler takes the slave view; the surrounding logic (or a bench) takes the master view.
interface uart_report_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) ();
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*CNT_W-1:0] cnt_data;
  logic [NUM_CH-1:0]       grant;
  logic                    tx_start;
  logic [7:0]              tx_data;
  logic                    tx_ready;
  logic                    busy;

  modport slave (
    input  req,
    input  cnt_data,
    input  tx_ready,
    output grant,
    output tx_start,
    output tx_data,
    output busy
  );

  modport master (
    output req,
    output cnt_data,
    output tx_ready,
    input  grant,
    input  tx_start,
    input  tx_data,
    input  busy
  );
endinterface

// File: rtl/uart_report_scheduler.sv
// Round-robin scheduler framing channel counts into byte-serial UART report packets.
// Optional feature: define UART_REPORT_CHECKSUM_EN to append an XOR checksum (5-byte packets).
module uart_report_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_report_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef UART_REPORT_CHECKSUM_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif
  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [IDX_W:0]   pick;

  // Returns {found, index}: first requester at or after the pointer, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CH-1:0] r,
                                             input logic [IDX_W-1:0]  p);
    logic [IDX_W:0] res;
    int             c;
    res = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      c = (int'(p) + k) % NUM_CH;
      if (r[c]) res = {1'b1, IDX_W'(c)};
    end
    return res;
  endfunction

  function automatic logic [7:0] pkt_byte(input logic [2:0]       i,
                                          input logic [IDX_W-1:0] id,
                                          input logic [15:0]      c);
    logic [7:0] idb;
    idb = 8'(id);
    case (i)
      3'd0:    pkt_byte = HDR;
      3'd1:    pkt_byte = idb;
      3'd2:    pkt_byte = c[15:8];
      3'd3:    pkt_byte = c[7:0];
`ifdef UART_REPORT_CHECKSUM_EN
      default: pkt_byte = HDR ^ idb ^ c[15:8] ^ c[7:0];
`else
      default: pkt_byte = 8'h00;
`endif
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
    if (w == IDX_W'(NUM_CH - 1)) next_ptr = '0;
    else                          next_ptr = w + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Count holding register is pure data; it is always reloaded in GRANT before use.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    pick    = rr_pick(bus.req, ptr_q);
    case (state_q)
      S_IDLE: begin
        if (pick[IDX_W]) begin
          win_d   = pick[IDX_W-1:0];
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d   = 16'(bus.cnt_data[int'(win_q)*CNT_W +: CNT_W]);
        ptr_d   = next_ptr(win_q);
        idx_d   = 3'd0;
        data_d  = HDR;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (bus.tx_ready) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!bus.tx_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.tx_ready) begin
          if (idx_q == 3'(NBYTES - 1)) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            data_d  = pkt_byte(idx_q + 3'd1, win_q, cnt_q);
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.grant    = '0;
    bus.tx_start = 1'b0;
    bus.busy     = (state_q != S_IDLE);
    bus.tx_data  = data_q;
    if (state_q == S_GRANT) bus.grant = NUM_CH'(1) << win_q;
    if (state_q == S_LOAD)  bus.tx_start = bus.tx_ready;
  end

  a_start_gap: assert property (@(posedge clk) disable iff (!rst_n)
    bus.tx_start |=> !bus.tx_start);
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.grant));
  a_start_ready: assert property (@(posedge clk) disable iff (!rst_n)
    bus.tx_start |-> bus.tx_ready);

endmodule
